maze_game_ctrl: RTL and testbench

//   Parametrised maze game controller: menu/difficulty selection, timed map preview,

---
 rtl/maze_pkg.sv | 35 +++
 rtl/maze_preview_timer.sv | 29 ++
 rtl/maze_game_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_maze_game_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/maze_pkg.sv
// Shared encodings for the maze game controller: FSM states, move-bit indices,
// difficulty codes and small elaboration-time width helpers.
package maze_pkg;

  typedef enum logic [2:0] {
    ST_MENU  = 3'd0,
    ST_SHOW  = 3'd1,
    ST_PLAY  = 3'd2,
    ST_CHECK = 3'd3,
    ST_LOST  = 3'd4,
    ST_WON   = 3'd5
  } state_e;

  localparam int unsigned DIR_UP    = 0;
  localparam int unsigned DIR_DOWN  = 1;
  localparam int unsigned DIR_LEFT  = 2;
  localparam int unsigned DIR_RIGHT = 3;

  localparam logic [1:0] DIFF_EASY = 2'd0;
  localparam logic [1:0] DIFF_MED  = 2'd1;
  localparam logic [1:0] DIFF_HARD = 2'd2;

  // Index width for n entries, never narrower than one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/maze_preview_timer.sv
// Map-preview countdown: loads a cycle count and decrements while enabled.
// done_c flags the cycle in which the count reaches zero.
module maze_preview_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         done_c
);

  logic [W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_val;
    end else if (en && (count_q != '0)) begin
      count_q <= count_q - W'(1);
    end
  end

  // A zero load also terminates at once rather than wrapping.
  assign done_c = en && (count_q <= W'(1));

endmodule

// File: rtl/maze_game_ctrl.sv
// Maze game controller: menu/difficulty, timed preview, hidden-map play with
// ROM-checked moves, and lose/win detection. Owns position, state and visibility.
module maze_game_ctrl
  import maze_pkg::*;
#(
  parameter int unsigned MAP_W     = 30,
  parameter int unsigned MAP_H     = 21,
  parameter int unsigned START_X   = 0,
  parameter int unsigned START_Y   = 11,
  parameter int unsigned GOAL_X    = 29,
  parameter int unsigned GOAL_Y    = 11,
  parameter int unsigned SHOW_EASY = 50000000,
  parameter int unsigned SHOW_MED  = 25000000,
  parameter int unsigned SHOW_HARD = 10000000,
  parameter int unsigned ROM_LAT   = 1,
  localparam int unsigned XW       = idx_w(MAP_W),
  localparam int unsigned YW       = idx_w(MAP_H)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_start,
  input  logic             btn_sel,
  input  logic [3:0]       move,
  output logic [YW-1:0]    map_addr,
  input  logic [MAP_W-1:0] map_data,
  output logic [XW-1:0]    player_x,
  output logic [YW-1:0]    player_y,
  output logic [1:0]       difficulty,
  output logic [2:0]       game_state,
  output logic             map_visible,
  output logic             busy,
  output logic             lost,
  output logic             won
);

  localparam int unsigned TW = idx_w(max3(SHOW_EASY, SHOW_MED, SHOW_HARD) + 1);
  localparam int unsigned LW = idx_w(ROM_LAT + 1);

  state_e        state_q, state_d;
  logic [XW-1:0] px_q, px_d, tx_q, tx_d;
  logic [YW-1:0] py_q, py_d, ty_q, ty_d;
  logic [YW-1:0] addr_q, addr_d;
  logic [1:0]    diff_q, diff_d;
  logic [LW-1:0] lat_q, lat_d;
  logic          vis_q, vis_d, busy_q, busy_d, lost_q, lost_d, won_q, won_d;

  logic          show_done_c;
  logic [TW-1:0] show_len_c;
  logic [XW-1:0] cand_x_c;
  logic [YW-1:0] cand_y_c;
  logic          blocked_c;

  always_comb begin
    unique case (diff_q)
      DIFF_MED:  show_len_c = TW'(SHOW_MED);
      DIFF_HARD: show_len_c = TW'(SHOW_HARD);
      default:   show_len_c = TW'(SHOW_EASY);
    endcase
  end

  maze_preview_timer #(
    .W (TW)
  ) u_preview_timer (
    .clk      (clk),
    .reset    (reset),
    .load     ((state_q == ST_MENU) && btn_start),
    .load_val (show_len_c),
    .en       (state_q == ST_SHOW),
    .done_c   (show_done_c)
  );

  // One-step target with up > down > left > right priority and edge blocking.
  always_comb begin
    cand_x_c  = px_q;
    cand_y_c  = py_q;
    blocked_c = 1'b0;
    if (move[DIR_UP]) begin
      blocked_c = (py_q == '0);
      cand_y_c  = py_q - YW'(1);
    end else if (move[DIR_DOWN]) begin
      blocked_c = (py_q == YW'(MAP_H - 1));
      cand_y_c  = py_q + YW'(1);
    end else if (move[DIR_LEFT]) begin
      blocked_c = (px_q == '0);
      cand_x_c  = px_q - XW'(1);
    end else if (move[DIR_RIGHT]) begin
      blocked_c = (px_q == XW'(MAP_W - 1));
      cand_x_c  = px_q + XW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    tx_d    = tx_q;
    ty_d    = ty_q;
    addr_d  = addr_q;
    diff_d  = diff_q;
    lat_d   = lat_q;
    vis_d   = vis_q;
    busy_d  = busy_q;
    lost_d  = lost_q;
    won_d   = won_q;

    unique case (state_q)
      ST_MENU: begin
        if (btn_start) begin
          state_d = ST_SHOW;
          vis_d   = 1'b1;
        end else if (btn_sel) begin
          diff_d = (diff_q == DIFF_HARD) ? DIFF_EASY : diff_q + 2'd1;
        end
      end
      ST_SHOW: begin
        if (show_done_c) begin
          state_d = ST_PLAY;
          vis_d   = 1'b0;
        end
      end
      ST_PLAY: begin
        if ((move != 4'd0) && !blocked_c) begin
          addr_d  = cand_y_c;
          tx_d    = cand_x_c;
          ty_d    = cand_y_c;
          lat_d   = '0;
          busy_d  = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        // The row addressed on entry is valid after ROM_LAT further edges.
        if (lat_q == LW'(ROM_LAT)) begin
          busy_d = 1'b0;
          if (map_data[tx_q]) begin
            state_d = ST_LOST;
            lost_d  = 1'b1;
            vis_d   = 1'b1;
          end else begin
            px_d = tx_q;
            py_d = ty_q;
            if ((tx_q == XW'(GOAL_X)) && (ty_q == YW'(GOAL_Y))) begin
              state_d = ST_WON;
              won_d   = 1'b1;
              vis_d   = 1'b1;
            end else begin
              state_d = ST_PLAY;
            end
          end
        end else begin
          lat_d = lat_q + LW'(1);
        end
      end
      ST_LOST, ST_WON: begin
        if (btn_start) begin
          state_d = ST_MENU;
          lost_d  = 1'b0;
          won_d   = 1'b0;
          vis_d   = 1'b0;
          px_d    = XW'(START_X);
          py_d    = YW'(START_Y);
        end
      end
      default: state_d = ST_MENU;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_MENU;
      px_q    <= XW'(START_X);
      py_q    <= YW'(START_Y);
      tx_q    <= '0;
      ty_q    <= '0;
      addr_q  <= '0;
      diff_q  <= DIFF_EASY;
      lat_q   <= '0;
      vis_q   <= 1'b0;
      busy_q  <= 1'b0;
      lost_q  <= 1'b0;
      won_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      tx_q    <= tx_d;
      ty_q    <= ty_d;
      addr_q  <= addr_d;
      diff_q  <= diff_d;
      lat_q   <= lat_d;
      vis_q   <= vis_d;
      busy_q  <= busy_d;
      lost_q  <= lost_d;
      won_q   <= won_d;
    end
  end

  assign map_addr    = addr_q;
  assign player_x    = px_q;
  assign player_y    = py_q;
  assign difficulty  = diff_q;
  assign game_state  = state_q;
  assign map_visible = vis_q;
  assign busy        = busy_q;
  assign lost        = lost_q;
  assign won         = won_q;

endmodule

// File: tb/tb_maze_game_ctrl.sv
// Self-checking bench for maze_game_ctrl on a small 8x4 maze with a 1-cycle ROM.
module tb_maze_game_ctrl;

  localparam int MAP_W = 8, MAP_H = 4, START_X = 0, START_Y = 1;
  localparam int GOAL_X = 7, GOAL_Y = 1;
  localparam int SHOW_EASY = 8, SHOW_MED = 5, SHOW_HARD = 3, ROM_LAT = 1;
  localparam int S_MENU = 0, S_SHOW = 1, S_PLAY = 2, S_CHECK = 3, S_LOST = 4, S_WON = 5;

  logic       clk, reset, btn_start, btn_sel;
  logic [3:0] move;
  logic [1:0] map_addr;
  logic [7:0] map_data;
  logic [2:0] player_x;
  logic [1:0] player_y;
  logic [1:0] difficulty;
  logic [2:0] game_state;
  logic       map_visible, busy, lost, won;

  logic [7:0] rom [MAP_H];
  int checks = 0;
  int passes = 0;
  int mx, my;

  maze_game_ctrl #(
    .MAP_W(MAP_W), .MAP_H(MAP_H), .START_X(START_X), .START_Y(START_Y),
    .GOAL_X(GOAL_X), .GOAL_Y(GOAL_Y), .SHOW_EASY(SHOW_EASY), .SHOW_MED(SHOW_MED),
    .SHOW_HARD(SHOW_HARD), .ROM_LAT(ROM_LAT)
  ) dut (
    .clk(clk), .reset(reset), .btn_start(btn_start), .btn_sel(btn_sel), .move(move),
    .map_addr(map_addr), .map_data(map_data), .player_x(player_x), .player_y(player_y),
    .difficulty(difficulty), .game_state(game_state), .map_visible(map_visible),
    .busy(busy), .lost(lost), .won(won)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous map ROM, one cycle of latency.
  always @(posedge clk) map_data <= rom[map_addr];

  function automatic logic [11:0] snap();
    return {game_state, player_x, player_y, lost, won, map_visible, busy};
  endfunction

  function automatic logic [11:0] expv(input int s, input int x, input int y, input int l,
                                       input int w, input int v, input int b);
    return {3'(s), 3'(x), 2'(y), 1'(l), 1'(w), 1'(v), 1'(b)};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic st, input logic sel, input logic [3:0] mv);
    btn_start = st; btn_sel = sel; move = mv;
    tick();
    btn_start = 1'b0; btn_sel = 1'b0; move = 4'd0;
  endtask

  task automatic run_preview(output int n);
    n = 0;
    while (game_state == 3'(S_SHOW) && n < 1000) begin
      n++;
      tick();
    end
  endtask

  task automatic new_map();
    for (int r = 0; r < MAP_H; r++) rom[r] = 8'($urandom & $urandom);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick(2);
    checks++;
    if (snap() !== expv(S_MENU, 0, 1, 0, 0, 0, 0))
      $display("FAIL reset_state got %h want %h", snap(), expv(S_MENU, 0, 1, 0, 0, 0, 0));
    else passes++;
    checks++;
    if ({difficulty, map_addr} !== 4'b0000)
      $display("FAIL reset_diff_addr got %b want 0000", {difficulty, map_addr});
    else passes++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_menu_preview();
    int ed, n;
    ed = 0;
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 1'b1, 4'd0);
      ed = (ed + 1) % 3;
      checks++;
      if (difficulty !== 2'(ed)) $display("FAIL sel_step%0d got %0d want %0d", i, difficulty, ed);
      else passes++;
    end
    pulse(1'b1, 1'b0, 4'd0);
    checks++;
    if (snap() !== expv(S_SHOW, 0, 1, 0, 0, 1, 0))
      $display("FAIL enter_show got %h want %h", snap(), expv(S_SHOW, 0, 1, 0, 0, 1, 0));
    else passes++;
    run_preview(n);
    checks++;
    if (n !== SHOW_EASY) $display("FAIL preview_easy_len got %0d want %0d", n, SHOW_EASY);
    else passes++;
    checks++;
    if (snap() !== expv(S_PLAY, 0, 1, 0, 0, 0, 0))
      $display("FAIL enter_play got %h want %h", snap(), expv(S_PLAY, 0, 1, 0, 0, 0, 0));
    else passes++;
  endtask

  task automatic test_wall_move();
    for (int r = 0; r < MAP_H; r++) rom[r] = 8'h00;
    rom[1] = 8'b0000_0100;
    pulse(1'b0, 1'b0, 4'b1000);
    checks++;
    if ({map_addr, busy, game_state} !== {2'd1, 1'b1, 3'(S_CHECK)})
      $display("FAIL check_issue got %b want %b", {map_addr, busy, game_state}, {2'd1, 1'b1, 3'(S_CHECK)});
    else passes++;
    tick();
    checks++;
    if (snap() !== expv(S_CHECK, 0, 1, 0, 0, 0, 1))
      $display("FAIL check_wait got %h want %h", snap(), expv(S_CHECK, 0, 1, 0, 0, 0, 1));
    else passes++;
    tick();
    checks++;
    if (snap() !== expv(S_PLAY, 1, 1, 0, 0, 0, 0))
      $display("FAIL free_commit got %h want %h", snap(), expv(S_PLAY, 1, 1, 0, 0, 0, 0));
    else passes++;
    pulse(1'b0, 1'b0, 4'b1000);
    tick(2);
    checks++;
    if (snap() !== expv(S_LOST, 1, 1, 1, 0, 1, 0))
      $display("FAIL wall_lost got %h want %h", snap(), expv(S_LOST, 1, 1, 1, 0, 1, 0));
    else passes++;
    pulse(1'b1, 1'b0, 4'd0);
    checks++;
    if (snap() !== expv(S_MENU, 0, 1, 0, 0, 0, 0))
      $display("FAIL lost_to_menu got %h want %h", snap(), expv(S_MENU, 0, 1, 0, 0, 0, 0));
    else passes++;
  endtask

  task automatic test_edge_priority();
    int n;
    for (int r = 0; r < MAP_H; r++) rom[r] = 8'h00;
    pulse(1'b1, 1'b0, 4'd0);
    run_preview(n);
    pulse(1'b0, 1'b0, 4'b0100);
    checks++;
    if (snap() !== expv(S_PLAY, 0, 1, 0, 0, 0, 0))
      $display("FAIL left_edge_drop got %h want %h", snap(), expv(S_PLAY, 0, 1, 0, 0, 0, 0));
    else passes++;
    pulse(1'b0, 1'b0, 4'b1001);
    checks++;
    if ({map_addr, busy} !== {2'd0, 1'b1})
      $display("FAIL up_priority got %b want %b", {map_addr, busy}, {2'd0, 1'b1});
    else passes++;
    tick(2);
    checks++;
    if (snap() !== expv(S_PLAY, 0, 0, 0, 0, 0, 0))
      $display("FAIL up_commit got %h want %h", snap(), expv(S_PLAY, 0, 0, 0, 0, 0, 0));
    else passes++;
    pulse(1'b0, 1'b0, 4'b0001);
    tick();
    checks++;
    if (snap() !== expv(S_PLAY, 0, 0, 0, 0, 0, 0))
      $display("FAIL top_edge_drop got %h want %h", snap(), expv(S_PLAY, 0, 0, 0, 0, 0, 0));
    else passes++;
    pulse(1'b0, 1'b0, 4'b0010);
    tick(2);
    checks++;
    if (snap() !== expv(S_PLAY, 0, 1, 0, 0, 0, 0))
      $display("FAIL down_commit got %h want %h", snap(), expv(S_PLAY, 0, 1, 0, 0, 0, 0));
    else passes++;
  endtask

  task automatic test_win();
    for (int i = 1; i <= 7; i++) begin
      pulse(1'b0, 1'b0, 4'b1000);
      tick(2);
      checks++;
      if (i < 7 && snap() !== expv(S_PLAY, i, 1, 0, 0, 0, 0))
        $display("FAIL walk_step%0d got %h want %h", i, snap(), expv(S_PLAY, i, 1, 0, 0, 0, 0));
      else if (i == 7 && snap() !== expv(S_WON, 7, 1, 0, 1, 1, 0))
        $display("FAIL goal_won got %h want %h", snap(), expv(S_WON, 7, 1, 0, 1, 1, 0));
      else passes++;
    end
    pulse(1'b1, 1'b0, 4'd0);
    checks++;
    if ({snap(), difficulty} !== {expv(S_MENU, 0, 1, 0, 0, 0, 0), 2'd0})
      $display("FAIL won_to_menu got %h want %h", {snap(), difficulty}, {expv(S_MENU, 0, 1, 0, 0, 0, 0), 2'd0});
    else passes++;
  endtask

  task automatic test_start_sel_same_cycle();
    int n;
    pulse(1'b0, 1'b1, 4'd0);
    pulse(1'b1, 1'b1, 4'd0);
    checks++;
    if ({difficulty, game_state} !== {2'd1, 3'(S_SHOW)})
      $display("FAIL start_beats_sel got %b want %b", {difficulty, game_state}, {2'd1, 3'(S_SHOW)});
    else passes++;
    run_preview(n);
    checks++;
    if (n !== SHOW_MED) $display("FAIL preview_med_len got %0d want %0d", n, SHOW_MED);
    else passes++;
  endtask

  task automatic test_check_drop_reset();
    for (int r = 0; r < MAP_H; r++) rom[r] = 8'h00;
    pulse(1'b0, 1'b0, 4'b1000);
    pulse(1'b0, 1'b0, 4'b0010);
    tick();
    checks++;
    if (snap() !== expv(S_PLAY, 1, 1, 0, 0, 0, 0))
      $display("FAIL check_drop got %h want %h", snap(), expv(S_PLAY, 1, 1, 0, 0, 0, 0));
    else passes++;
    tick(3);
    checks++;
    if (snap() !== expv(S_PLAY, 1, 1, 0, 0, 0, 0))
      $display("FAIL no_queue got %h want %h", snap(), expv(S_PLAY, 1, 1, 0, 0, 0, 0));
    else passes++;
    pulse(1'b0, 1'b0, 4'b1000);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if ({snap(), difficulty} !== {expv(S_MENU, 0, 1, 0, 0, 0, 0), 2'd0})
      $display("FAIL reset_in_check got %h want %h", {snap(), difficulty}, {expv(S_MENU, 0, 1, 0, 0, 0, 0), 2'd0});
    else passes++;
  endtask

  // Random walk on random maps; the model steps an (x,y) pair by the move rules.
  task automatic test_random();
    int n, dx, dy, nx, ny;
    logic [3:0] mv;
    logic [7:0] row;
    new_map();
    pulse(1'b1, 1'b0, 4'd0);
    run_preview(n);
    mx = START_X; my = START_Y;
    for (int it = 0; it < 150; it++) begin
      mv = 4'($urandom_range(0, 15));
      dx = 0; dy = 0;
      if (mv[0]) dy = -1;
      else if (mv[1]) dy = 1;
      else if (mv[2]) dx = -1;
      else if (mv[3]) dx = 1;
      nx = mx + dx; ny = my + dy;
      pulse(1'b0, 1'b0, mv);
      if (mv == 4'd0 || nx < 0 || nx >= MAP_W || ny < 0 || ny >= MAP_H) begin
        checks++;
        if (snap() !== expv(S_PLAY, mx, my, 0, 0, 0, 0))
          $display("FAIL rnd_drop it%0d got %h want %h", it, snap(), expv(S_PLAY, mx, my, 0, 0, 0, 0));
        else passes++;
        continue;
      end
      checks++;
      if ({map_addr, busy, game_state} !== {2'(ny), 1'b1, 3'(S_CHECK)})
        $display("FAIL rnd_issue it%0d got %b want %b", it, {map_addr, busy, game_state}, {2'(ny), 1'b1, 3'(S_CHECK)});
      else passes++;
      if ($urandom_range(0, 1) == 1) pulse(1'b0, 1'b0, 4'($urandom_range(1, 15)));
      else tick();
      tick();
      row = rom[ny];
      if (row[nx]) begin
        checks++;
        if (snap() !== expv(S_LOST, mx, my, 1, 0, 1, 0))
          $display("FAIL rnd_lost it%0d got %h want %h", it, snap(), expv(S_LOST, mx, my, 1, 0, 1, 0));
        else passes++;
      end else begin
        mx = nx; my = ny;
        if (mx == GOAL_X && my == GOAL_Y) begin
          checks++;
          if (snap() !== expv(S_WON, mx, my, 0, 1, 1, 0))
            $display("FAIL rnd_won it%0d got %h want %h", it, snap(), expv(S_WON, mx, my, 0, 1, 1, 0));
          else passes++;
        end else begin
          checks++;
          if (snap() !== expv(S_PLAY, mx, my, 0, 0, 0, 0))
            $display("FAIL rnd_move it%0d got %h want %h", it, snap(), expv(S_PLAY, mx, my, 0, 0, 0, 0));
          else passes++;
          continue;
        end
      end
      pulse(1'b1, 1'b0, 4'd0);
      new_map();
      pulse(1'b1, 1'b0, 4'd0);
      run_preview(n);
      checks++;
      if (n !== SHOW_EASY) $display("FAIL rnd_preview it%0d got %0d want %0d", it, n, SHOW_EASY);
      else passes++;
      mx = START_X; my = START_Y;
    end
  endtask

  initial begin
    reset = 1'b0; btn_start = 1'b0; btn_sel = 1'b0; move = 4'd0;
    for (int r = 0; r < MAP_H; r++) rom[r] = 8'h00;
    test_reset();
    test_menu_preview();
    test_wall_move();
    test_edge_priority();
    test_win();
    test_start_sel_same_cycle();
    test_check_drop_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
